// File: rtl/high_bit_scan_ctrl_if.sv
// high_bit_scan_ctrl_if: groups the request stream, search-stage hookup and
// index stream of high_bit_scan_ctrl into one bundle.
// master: controller side (drives req_ready, search_data, idx_*, done, busy).
// slave : environment side (drives req_valid/req_vector, idx_ready, search results).
interface high_bit_scan_ctrl_if #(
  parameter int INPUT_WIDTH = 8
);
  localparam int OUTPUT_WIDTH = $clog2(INPUT_WIDTH);

  logic                    req_valid;
  logic                    req_ready;
  logic [INPUT_WIDTH-1:0]  req_vector;

  logic [INPUT_WIDTH-1:0]  search_data;
  logic                    search_valid_flag;
  logic [OUTPUT_WIDTH-1:0] search_index;

  logic                    idx_valid;
  logic                    idx_ready;
  logic [OUTPUT_WIDTH-1:0] idx_data;
  logic                    idx_last;

  logic                    done;
  logic                    busy;

  modport master (
    input  req_valid, req_vector, search_valid_flag, search_index, idx_ready,
    output req_ready, search_data, idx_valid, idx_data, idx_last, done, busy
  );

  modport slave (
    output req_valid, req_vector, search_valid_flag, search_index, idx_ready,
    input  req_ready, search_data, idx_valid, idx_data, idx_last, done, busy
  );
endinterface

// File: rtl/high_bit_scan_ctrl.sv
// high_bit_scan_ctrl: takes a request vector and reports every set bit index,
//   highest first, by repeatedly running the pipelined highest-set-bit search
//   stage over a working copy and clearing each reported bit.
// Latency: an index is presented SEARCH_LAT+1 cycles after every work update;
//   with idx_ready held high one index leaves every SEARCH_LAT+2 cycles.
// Backpressure: idx_data/idx_last hold while idx_ready is low; req_ready is
//   only high in IDLE, so requests offered while busy simply wait.
// Ports: clk/rst (async active-high), bus (high_bit_scan_ctrl_if.master).
// Optional build macro HIGH_BIT_SCAN_CHECK_EN adds a sticky err output that
//   flags a search result that is invalid or disagrees with the work vector.
module high_bit_scan_ctrl #(
  parameter int INPUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  high_bit_scan_ctrl_if.master bus
`ifdef HIGH_BIT_SCAN_CHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int OUTPUT_WIDTH = $clog2(INPUT_WIDTH);
  localparam int SEARCH_LAT   = (INPUT_WIDTH > 2) ? OUTPUT_WIDTH : 1;
  localparam int CNT_W        = $clog2(SEARCH_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEARCH_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  work_q, work_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUTPUT_WIDTH-1:0] idx_data_q, idx_data_d;
  logic                    idx_last_q, idx_last_d;
  logic                    done_q, done_d;
  // Holds req_ready low until the first clock edge after reset release.
  logic                    armed_q;

  logic [INPUT_WIDTH-1:0]  cap_mask;   // one-hot of the search result
  logic [INPUT_WIDTH-1:0]  ack_mask;   // one-hot of the presented index
  logic [INPUT_WIDTH-1:0]  work_left;  // work with the presented bit removed
  logic                    capture;    // last WAIT cycle: search output is due
  logic                    req_ready_int;

  always_comb begin
    cap_mask = '0;
    cap_mask[bus.search_index] = 1'b1;
    ack_mask = '0;
    ack_mask[idx_data_q] = 1'b1;
  end

  assign work_left     = work_q & ~ack_mask;
  assign capture       = (state_q == WAIT) && (cnt_q == '0);
  assign req_ready_int = armed_q && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    idx_data_d = idx_data_q;
    idx_last_d = idx_last_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_int) begin
          if (|bus.req_vector) begin
            work_d  = bus.req_vector;
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end else begin
            // Nothing to scan: finish immediately without touching work.
            done_d = 1'b1;
          end
        end
      end

      WAIT: begin
        // work has been stable since entry, so after SEARCH_LAT edges the
        // search output corresponds to it.
        if (cnt_q == '0) begin
          idx_data_d = bus.search_index;
          idx_last_d = ((work_q & ~cap_mask) == '0);
          state_d    = PRESENT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      PRESENT: begin
        if (bus.idx_ready) begin
          work_d = work_left;
          if (|work_left) begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      idx_data_q <= '0;
      idx_last_q <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      idx_data_q <= idx_data_d;
      idx_last_q <= idx_last_d;
      done_q     <= done_d;
      armed_q    <= 1'b1;
    end
  end

  assign bus.req_ready   = req_ready_int;
  assign bus.search_data = work_q;
  assign bus.idx_valid   = (state_q == PRESENT);
  assign bus.idx_data    = idx_data_q;
  assign bus.idx_last    = idx_last_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef HIGH_BIT_SCAN_CHECK_EN
  // Reference highest set bit of work; ascending scan so the top bit wins.
  logic [OUTPUT_WIDTH-1:0] hsb_work;
  logic                    err_q, err_d;

  always_comb begin
    hsb_work = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (work_q[i]) hsb_work = OUTPUT_WIDTH'(i);
    end
  end

  always_comb begin
    err_d = err_q;
    if (capture && (!bus.search_valid_flag || (bus.search_index != hsb_work))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  // The valid flag is only consulted by the optional checker.
  logic unused_search_flag;
  logic unused_capture;
  assign unused_search_flag = bus.search_valid_flag;
  assign unused_capture     = capture;
`endif

endmodule
